// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding req/ack fetch into IR, one-entry skid
// buffer for responses that land while decode stalls, and redirect with in-flight drain.
module fetch_unit #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP   = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        br_en,
  input  logic [31:0] br_target,
  output logic [31:0] IR,
  output logic        ir_valid,
  output logic [31:0] pc_out
);

  typedef enum logic [1:0] {StIdle, StReq, StHold, StDrain} state_e;

  localparam logic [31:0] ResetPc = {RESET_VEC[31:2], 2'b00};

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [31:0] ir_q, ir_d;
  logic        ir_valid_q, ir_valid_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [31:0] buf_addr_q, buf_addr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      fetch_pc_q   <= ResetPc;
      drain_addr_q <= 32'h0;
      ir_q         <= 32'h0;
      ir_valid_q   <= 1'b0;
      pc_out_q     <= 32'h0;
      buf_data_q   <= 32'h0;
      buf_addr_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
      ir_q         <= ir_d;
      ir_valid_q   <= ir_valid_d;
      pc_out_q     <= pc_out_d;
      buf_data_q   <= buf_data_d;
      buf_addr_q   <= buf_addr_d;
    end
  end

  // Outputs derive from state so an async reset drops the request immediately.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = 32'h0;
    unique case (state_q)
      StReq: begin
        imem_req  = 1'b1;
        imem_addr = fetch_pc_q;
      end
      StDrain: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    ir_d         = ir_q;
    ir_valid_d   = ir_valid_q;
    pc_out_d     = pc_out_q;
    buf_data_d   = buf_data_q;
    buf_addr_d   = buf_addr_q;

    if (ir_valid_q && !stall) ir_valid_d = 1'b0;

    if (br_en) begin
      fetch_pc_d = {br_target[31:2], 2'b00};
      ir_valid_d = 1'b0;
      // An unanswered request must still complete; its address is frozen for the drain.
      if (imem_req && !imem_ack) begin
        state_d = StDrain;
        if (state_q == StReq) drain_addr_d = fetch_pc_q;
      end else begin
        state_d = StReq;
      end
    end else begin
      unique case (state_q)
        StIdle: state_d = StReq;
        StReq: begin
          if (imem_ack) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
            if (!ir_valid_q || !stall) begin
              ir_d       = imem_rdata;
              pc_out_d   = fetch_pc_q;
              ir_valid_d = 1'b1;
            end else begin
              buf_data_d = imem_rdata;
              buf_addr_d = fetch_pc_q;
              state_d    = StHold;
            end
          end
        end
        StHold: begin
          if (!stall) begin
            ir_d       = buf_data_q;
            pc_out_d   = buf_addr_q;
            ir_valid_d = 1'b1;
            state_d    = StReq;
          end
        end
        StDrain: begin
          if (imem_ack) state_d = StReq;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign IR       = ir_q;
  assign ir_valid = ir_valid_q;
  assign pc_out   = pc_out_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized memory latency, stalls and
// redirects checked against a program-order stream model of consumed instructions.
module tb_fetch_unit;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] XOR_KEY   = 32'hE000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        br_en = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic [31:0] IR;
  logic        ir_valid;
  logic [31:0] pc_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_VEC(RESET_VEC),
    .PC_STEP  (32'd4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .stall     (stall),
    .br_en     (br_en),
    .br_target (br_target),
    .IR        (IR),
    .ir_valid  (ir_valid),
    .pc_out    (pc_out)
  );

  // Memory contents: every word is its own address with the top bits flipped.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ XOR_KEY;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    stall      = 1'b0;
    br_en      = 1'b0;
    br_target  = 32'h0;
  endtask

  // Leaves the DUT one edge after reset release, i.e. requesting RESET_VEC.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({imem_req, imem_addr, IR, ir_valid, pc_out} !== {1'b0, 32'h0, 32'h0, 1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_state: got req=%0b addr=%h ir=%h v=%0b pc=%h want all zero",
               imem_req, imem_addr, IR, ir_valid, pc_out);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_no_req: got req=%0b want 0", imem_req);
    end
    tick();
    n_cmp++;
    if ({imem_req, imem_addr} !== {1'b1, RESET_VEC}) begin
      n_bad++;
      $display("FAIL first_req: got req=%0b addr=%h want 1 %h", imem_req, imem_addr, RESET_VEC);
    end
  endtask

  task automatic test_zero_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      imem_ack   = imem_req;
      imem_rdata = word_at(imem_addr);
      tick();
      n_cmp++;
      if ({imem_addr, IR, pc_out, ir_valid} !==
          {32'(4 * (i + 1)), word_at(32'(4 * i)), 32'(4 * i), 1'b1}) begin
        n_bad++;
        $display("FAIL zero_wait_%0d: got addr=%h ir=%h pc=%h v=%0b want addr=%h ir=%h pc=%h v=1",
                 i, imem_addr, IR, pc_out, ir_valid, 32'(4 * (i + 1)), word_at(32'(4 * i)),
                 32'(4 * i));
      end
    end
    idle_inputs();
  endtask

  task automatic test_wait_states();
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 32'(4 * r)}) begin
          n_bad++;
          $display("FAIL wait_addr_r%0d_k%0d: got req=%0b addr=%h want 1 %h",
                   r, k, imem_req, imem_addr, 32'(4 * r));
        end
        if (k == 3) begin
          n_cmp++;
          if (ir_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL wait_gap_r%0d: got ir_valid=%0b want 0", r, ir_valid);
          end
        end
        imem_ack   = (k == 3);
        imem_rdata = word_at(imem_addr);
        tick();
      end
      imem_ack = 1'b0;
      n_cmp++;
      if ({ir_valid, pc_out, IR} !== {1'b1, 32'(4 * r), word_at(32'(4 * r))}) begin
        n_bad++;
        $display("FAIL wait_ir_r%0d: got v=%0b pc=%h ir=%h want 1 %h %h",
                 r, ir_valid, pc_out, IR, 32'(4 * r), word_at(32'(4 * r)));
      end
    end
    idle_inputs();
  endtask

  task automatic test_hold();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      imem_ack   = 1'b1;
      imem_rdata = word_at(imem_addr);
      tick();
    end
    stall      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = word_at(imem_addr);
    tick();
    // Stray ack while not requesting must be ignored.
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({imem_req, ir_valid, pc_out, IR} !== {1'b0, 1'b1, 32'h4, word_at(32'h4)}) begin
        n_bad++;
        $display("FAIL hold_%0d: got req=%0b v=%0b pc=%h ir=%h want 0 1 00000004 %h",
                 k, imem_req, ir_valid, pc_out, IR, word_at(32'h4));
      end
      tick();
    end
    imem_ack = 1'b0;
    stall    = 1'b0;
    tick();
    n_cmp++;
    if ({imem_req, imem_addr, ir_valid, pc_out, IR} !==
        {1'b1, 32'hC, 1'b1, 32'h8, word_at(32'h8)}) begin
      n_bad++;
      $display("FAIL hold_release: got req=%0b addr=%h v=%0b pc=%h ir=%h want 1 0000000c 1 8 %h",
               imem_req, imem_addr, ir_valid, pc_out, IR, word_at(32'h8));
    end
    idle_inputs();
  endtask

  task automatic test_branch();
    do_reset();
    for (int i = 0; i < 20 && imem_addr !== 32'h10; i++) begin
      imem_ack   = 1'b1;
      imem_rdata = word_at(imem_addr);
      tick();
    end
    imem_ack = 1'b0;
    n_cmp++;
    if (imem_addr !== 32'h10) begin
      n_bad++;
      $display("FAIL br_reach: got addr=%h want 00000010", imem_addr);
    end
    br_en     = 1'b1;
    br_target = 32'h103;
    tick();
    br_en = 1'b0;
    n_cmp++;
    if ({imem_req, imem_addr, ir_valid} !== {1'b1, 32'h10, 1'b0}) begin
      n_bad++;
      $display("FAIL br_drain: got req=%0b addr=%h v=%0b want 1 00000010 0",
               imem_req, imem_addr, ir_valid);
    end
    tick();
    imem_ack   = 1'b1;
    imem_rdata = word_at(imem_addr);
    tick();
    imem_ack = 1'b0;
    n_cmp++;
    if ({imem_req, imem_addr, ir_valid} !== {1'b1, 32'h100, 1'b0}) begin
      n_bad++;
      $display("FAIL br_redirect: got req=%0b addr=%h v=%0b want 1 00000100 0",
               imem_req, imem_addr, ir_valid);
    end
    imem_ack   = 1'b1;
    imem_rdata = word_at(imem_addr);
    tick();
    imem_ack = 1'b0;
    n_cmp++;
    if ({ir_valid, pc_out, IR, imem_addr} !== {1'b1, 32'h100, word_at(32'h100), 32'h104}) begin
      n_bad++;
      $display("FAIL br_first_ir: got v=%0b pc=%h ir=%h addr=%h want 1 00000100 %h 00000104",
               ir_valid, pc_out, IR, imem_addr, word_at(32'h100));
    end
  endtask

  // Runs straight after test_branch: DUT is requesting 0x104 with IR valid.
  task automatic test_br_stall_ack();
    stall      = 1'b1;
    br_en      = 1'b1;
    br_target  = 32'h200;
    imem_ack   = 1'b1;
    imem_rdata = word_at(imem_addr);
    tick();
    idle_inputs();
    n_cmp++;
    if ({imem_req, imem_addr, ir_valid} !== {1'b1, 32'h200, 1'b0}) begin
      n_bad++;
      $display("FAIL br_stall_ack: got req=%0b addr=%h v=%0b want 1 00000200 0",
               imem_req, imem_addr, ir_valid);
    end
    imem_ack   = 1'b1;
    imem_rdata = word_at(imem_addr);
    tick();
    imem_ack = 1'b0;
    n_cmp++;
    if ({ir_valid, pc_out, IR} !== {1'b1, 32'h200, word_at(32'h200)}) begin
      n_bad++;
      $display("FAIL br_stall_next: got v=%0b pc=%h ir=%h want 1 00000200 %h",
               ir_valid, pc_out, IR, word_at(32'h200));
    end
  endtask

  task automatic test_reset_mid_and_wrap();
    stall    = 1'b1;
    imem_ack = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({imem_req, ir_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL async_reset: got req=%0b v=%0b want 0 0", imem_req, ir_valid);
    end
    idle_inputs();
    tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({imem_req, imem_addr} !== {1'b1, RESET_VEC}) begin
      n_bad++;
      $display("FAIL reset_restart: got req=%0b addr=%h want 1 %h", imem_req, imem_addr, RESET_VEC);
    end
    imem_ack   = 1'b1;
    imem_rdata = word_at(imem_addr);
    br_en      = 1'b1;
    br_target  = 32'hFFFF_FFFF;
    tick();
    br_en = 1'b0;
    n_cmp++;
    if ({imem_req, imem_addr, ir_valid} !== {1'b1, 32'hFFFF_FFFC, 1'b0}) begin
      n_bad++;
      $display("FAIL wrap_target: got req=%0b addr=%h v=%0b want 1 fffffffc 0",
               imem_req, imem_addr, ir_valid);
    end
    imem_rdata = word_at(imem_addr);
    tick();
    imem_ack = 1'b0;
    n_cmp++;
    if ({imem_addr, ir_valid, pc_out, IR} !==
        {32'h0, 1'b1, 32'hFFFF_FFFC, word_at(32'hFFFF_FFFC)}) begin
      n_bad++;
      $display("FAIL wrap_next: got addr=%h v=%0b pc=%h ir=%h want 00000000 1 fffffffc %h",
               imem_addr, ir_valid, pc_out, IR, word_at(32'hFFFF_FFFC));
    end
    idle_inputs();
  endtask

  // Consumed instructions must follow program order: sequential, restarting at each target.
  task automatic test_random(input int n, input int max_lat, input int stall_pct,
                             input int br_pct);
    logic [31:0] exp_pc;
    int          lat;
    int          consumed;
    do_reset();
    exp_pc   = RESET_VEC;
    lat      = $urandom_range(0, max_lat);
    consumed = 0;
    for (int c = 0; c < n; c++) begin
      stall     = ($urandom_range(0, 99) < stall_pct);
      br_en     = ($urandom_range(0, 99) < br_pct);
      br_target = $urandom;
      if (imem_req && lat == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = word_at(imem_addr);
      end else begin
        imem_ack   = !imem_req && ($urandom_range(0, 3) == 0);
        imem_rdata = $urandom;
      end
      if (br_en) begin
        exp_pc = {br_target[31:2], 2'b00};
      end else if (ir_valid && !stall) begin
        n_cmp++;
        if ({pc_out, IR} !== {exp_pc, word_at(exp_pc)}) begin
          n_bad++;
          $display("FAIL rand_stream_c%0d: got pc=%h ir=%h want pc=%h ir=%h",
                   c, pc_out, IR, exp_pc, word_at(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (imem_req) begin
        if (imem_ack) lat = $urandom_range(0, max_lat);
        else lat--;
      end
      tick();
    end
    idle_inputs();
    n_cmp++;
    if (consumed < n / 12) begin
      n_bad++;
      $display("FAIL rand_progress: got %0d consumed want at least %0d", consumed, n / 12);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_hold();
    test_branch();
    test_br_stall_ack();
    test_reset_mid_and_wrap();
    test_random(400, 0, 20, 3);
    test_random(600, 3, 30, 5);
    test_random(600, 5, 50, 8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decode/instruction register stage.
- Maintains the fetch PC and issues single-outstanding word requests to instruction memory over a req/ack handshake.
- Holds the returned word in IR with a valid flag; decode consumes IR when not stalled.
- Accepts branch redirects from the decode/branch logic; has a one-entry skid buffer for responses that arrive while decode is stalled.

Parameters:
- RESET_VEC, 32'h0000_0000, first fetch address after reset; bits [1:0] ignored.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction memory request.
- imem_addr  out  32  word-aligned fetch address; stable while imem_req=1 and imem_ack=0.
- imem_ack  in  1  response strobe; imem_rdata valid this cycle; sampled only while imem_req=1.
- imem_rdata  in  32  instruction word.
- stall  in  1  downstream not accepting; IR/ir_valid/pc_out hold.
- br_en  in  1  single-cycle redirect request.
- br_target  in  32  redirect address; bits [1:0] forced to 0.
- IR  out  32  instruction to decode.
- ir_valid  out  1  IR holds a valid instruction.
- pc_out  out  32  address of the instruction in IR.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, fetch_pc=RESET_VEC&~3, imem_req=0, imem_addr=0, IR=0, ir_valid=0, pc_out=0, buffer empty.
- States: IDLE, REQ, HOLD, DRAIN.
- IDLE: first edge after reset release -> REQ, imem_req=1, imem_addr=fetch_pc.
- REQ: imem_req=1, imem_addr=fetch_pc.
  - On ack with slot free (ir_valid=0 or stall=0): IR<=rdata, pc_out<=fetch_pc, ir_valid<=1, fetch_pc+=PC_STEP; stay in REQ. Next request starts the following cycle, so a zero-wait memory sustains 1 instr/cycle.
  - On ack with slot busy (ir_valid=1 and stall=1): rdata and address go to the buffer, fetch_pc+=PC_STEP, imem_req<=0 -> HOLD.
- HOLD: imem_req=0. When stall=0: IR<=buffer, pc_out<=buffered address, ir_valid=1, buffer emptied -> REQ.
- DRAIN: imem_req stays 1 with the old address until ack. The response is discarded. Then -> REQ at the redirected fetch_pc.
- Consumption: ir_valid with stall=0 at an edge means consumed. If nothing is loaded that edge, ir_valid<=0.
- Redirect (br_en=1), highest priority, any state:
  - fetch_pc<=br_target&~3; ir_valid<=0; buffer emptied.
  - Any ack in the same cycle is discarded.
  - If a request is in flight without ack this cycle -> DRAIN; otherwise -> REQ.
  - br_en overrides stall.
- br_en while in DRAIN: fetch_pc updated to the newest target; stay in DRAIN.
- imem_ack while imem_req=0: ignored.
- fetch_pc wraps modulo 2^32 (0xFFFF_FFFC + 4 = 0).
- The request handshake is never abandoned except by reset. Reset mid-request drops imem_req immediately (async).

Test Plan:
- Reset release, zero-wait memory returning addr^0xE000_0000, stall=0 -> imem_addr 0,4,8 on consecutive cycles; IR=0xE000_0000,0xE000_0004 with pc_out 0,4; ir_valid=1 from the 2nd cycle after release.
- Ack delayed 3 cycles per request -> imem_addr held stable for 4 cycles; ir_valid drops between instructions; no address skipped.
- stall=1 while IR valid, ack arrives for addr 8 -> HOLD, imem_req=0, IR unchanged. Release stall -> IR=word@8, pc_out=8, next request addr 0xC.
- br_en, br_target=0x103 while a request to 0x10 is pending (ack 2 cycles later) -> ir_valid=0; the 0x10 response is discarded; next request is 0x100; pc_out=0x100 for the following IR.
- br_en and stall in the same cycle with ack -> ack data discarded, ir_valid=0, next addr=target.
- Assert rst low mid-request -> imem_req=0 and ir_valid=0 immediately. After release, the first request is RESET_VEC; fetch from 0xFFFF_FFFC -> next addr 0x0000_0000.
